trace_stream_receiver: RTL and testbench
========================================

Name: trace_stream_receiver

Overview:
- AXI-Stream slave that consumes the {pc, instr} trace beats produced by the continuous monitoring system.
- Unpacks each beat, buffers it in a small FIFO and presents pc/instr to a downstream consumer over valid/ready.
- Checks packet framing against tlast_interval and the WFI force-tlast rule, and keeps beat and packet counters.
- Sits on the PL side as a loopback checker, or as the front end of an on-chip trace analyser.

Parameters:
XLEN, 64, pc width
AXI_DATA_WIDTH, XLEN+32, stream beat width; pc in [AXI_DATA_WIDTH-1:32], instr in [31:0]
FIFO_DEPTH, 8, buffer entries; power of two, >=2
WFI_INSTRUCTION, 32'h0001, instr value that legally forces tlast

Ports:
clk  in  1  single clock
rst_n  in  1  asynchronous active-low reset
S_AXIS_tvalid  in  1  beat valid
S_AXIS_tready  out  1  beat accept
S_AXIS_tdata  in  AXI_DATA_WIDTH  {pc, instr}
S_AXIS_tlast  in  1  packet end
tlast_interval  in  32  expected beats per packet; 0 = interval check disabled
out_valid  out  1  unpacked beat available
out_ready  in  1  consumer accepts
out_pc  out  XLEN  pc of head entry
out_instr  out  32  instr of head entry
out_last  out  1  tlast of head entry
ctrl_clear  in  1  level; clears counters, error flags and FSM (not FIFO contents)
beat_count  out  32  accepted beats, wraps mod 2^32
packet_count  out  32  accepted tlast beats, wraps mod 2^32
err_early_tlast  out  1  sticky: tlast before interval on a non-WFI beat
err_missing_tlast  out  1  sticky: interval reached without tlast
err_after_wfi  out  1  sticky: beat accepted in RX_DONE
wfi_seen  out  1  sticky: WFI beat with tlast received

Behaviour:
- Reset (async assert, sync deassert by clk): FIFO empty, out_valid=0, S_AXIS_tready=0 while rst_n=0 and 1 from the first clk edge after release. All counters 0, all flags 0, FSM=RX_IDLE, beat_in_pkt=0.
- Accept rule: a beat is accepted when S_AXIS_tvalid & S_AXIS_tready. S_AXIS_tready = ~full, registered-free and derived from the FIFO count. No push while full, even if a pop happens in the same cycle.
- Latency: a beat accepted at edge N is visible on out_* after edge N (out_valid=1 in cycle N+1 if the FIFO was empty). Pop occurs when out_valid & out_ready. Simultaneous push and pop when not full keeps the count unchanged. out_* hold stable while out_valid & ~out_ready.
- Counters: beat_count += 1 per accepted beat. packet_count += 1 per accepted beat with tlast.
- beat_in_pkt (32 bit): n = beat_in_pkt+1 on the accepted beat. On tlast or on (interval != 0 and n == interval), beat_in_pkt is set to 0; otherwise it becomes n.
- Framing check per accepted beat, with interval != 0:
  - tlast & n != interval & instr != WFI_INSTRUCTION sets err_early_tlast.
  - ~tlast & n == interval sets err_missing_tlast.
  - With interval == 0 only the WFI checks apply.
- FSM, advanced by accepted beats only:
  - RX_IDLE: any beat moves to RX_BODY, unless the beat is tlast (stays in RX_IDLE).
  - RX_BODY: a tlast beat moves to RX_IDLE.
  - From either state, an accepted beat with instr==WFI_INSTRUCTION and tlast sets wfi_seen and moves to RX_DONE.
  - RX_DONE: beats are still accepted and buffered; each sets err_after_wfi; no state change.
- A WFI beat without tlast sets err_missing_tlast (force-tlast rule violated), regardless of interval.
- ctrl_clear, synchronous and higher priority than updates in the same cycle: counters, flags and beat_in_pkt go to 0, FSM goes to RX_IDLE. FIFO and handshake are unaffected; a beat accepted during clear is buffered but not counted.
- Reset mid-packet: the FIFO is emptied and buffered beats are discarded. The transmitter must also be reset; no recovery of partial packets.
- tlast_interval changes take effect on the next accepted beat. No latching.

Decomposition:
- Shared package: WFI_INSTRUCTION constant (shared with the transmitter), FSM state typedef (RX_IDLE, RX_BODY, RX_DONE), field offsets for the pc/instr split of the beat.
- One sub-module: trace_rx_fifo, a synchronous FIFO of width AXI_DATA_WIDTH+1 and depth FIFO_DEPTH, with full/empty/count and the async active-low reset.

Test Plan:
- interval=4, 8 beats pc=0x1000..0x101C, tlast on beats 4 and 8, out_ready=1 -> out_pc in order with 1-cycle latency; beat_count=8, packet_count=2; no errors.
- out_ready=0, 10 beats offered with FIFO_DEPTH=8 -> exactly 8 accepted, tready=0 after the 8th. Then out_ready=1 for 1 cycle -> tready returns 1 the next cycle; no beat lost or duplicated.
- interval=4, tlast on beat 2 with instr=0x13 -> err_early_tlast=1. Repeat with instr=0x0001 -> wfi_seen=1, no error, FSM=RX_DONE.
- interval=3, 3 beats without tlast -> err_missing_tlast=1 after the 3rd; beat_in_pkt restarts at 0.
- After the WFI tlast, send 1 more beat -> accepted, err_after_wfi=1. Pulse ctrl_clear -> all counters and flags 0, FSM=RX_IDLE.
- Assert rst_n=0 asynchronously mid-packet with 5 beats buffered -> out_valid=0 immediately, counts 0, tready=1 on the first edge after release.

Source files
------------

// File: rtl/trace_stream_receiver_pkg.sv
// Shared definitions for the trace stream receiver: WFI marker, FSM states
// and the {pc, instr} field layout of a stream beat.
package trace_stream_receiver_pkg;

    localparam logic [31:0] WFI_INSTR = 32'h0000_0001;

    localparam int unsigned INSTR_LSB   = 0;
    localparam int unsigned INSTR_WIDTH = 32;
    localparam int unsigned PC_LSB      = INSTR_LSB + INSTR_WIDTH;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_BODY,
        RX_DONE
    } rx_state_e;

endpackage

// File: rtl/trace_rx_fifo.sv
// Synchronous FIFO buffering received beats; head entry is presented combinationally.
module trace_rx_fifo #(
    parameter int unsigned Width = 97,
    parameter int unsigned Depth = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [Width-1:0]           wdata,
    input  logic                       pop,
    output logic [Width-1:0]           rdata,
    output logic                       empty,
    output logic [$clog2(Depth):0]     count
);

    localparam int unsigned AddrW = $clog2(Depth);
    localparam logic [AddrW:0] FullCount = (AddrW + 1)'(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AddrW:0]   count_q;
    logic             full, do_push, do_pop;

    assign full    = (count_q == FullCount);
    assign empty   = (count_q == '0);
    // A pop in the same cycle never frees room for a push while full.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (do_push && !do_pop)      count_q <= count_q + 1'b1;
            else if (do_pop && !do_push) count_q <= count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/trace_stream_receiver.sv
// AXI-Stream trace receiver: buffers {pc, instr} beats, checks packet framing
// against tlast_interval and the WFI force-tlast rule, and counts beats/packets.
module trace_stream_receiver
    import trace_stream_receiver_pkg::*;
#(
    parameter int unsigned XLEN            = 64,
    parameter int unsigned AXI_DATA_WIDTH  = XLEN + 32,
    parameter int unsigned FIFO_DEPTH      = 8,
    parameter logic [31:0] WFI_INSTRUCTION = WFI_INSTR
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      S_AXIS_tvalid,
    output logic                      S_AXIS_tready,
    input  logic [AXI_DATA_WIDTH-1:0] S_AXIS_tdata,
    input  logic                      S_AXIS_tlast,
    input  logic [31:0]               tlast_interval,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [XLEN-1:0]           out_pc,
    output logic [31:0]               out_instr,
    output logic                      out_last,
    input  logic                      ctrl_clear,
    output logic [31:0]               beat_count,
    output logic [31:0]               packet_count,
    output logic                      err_early_tlast,
    output logic                      err_missing_tlast,
    output logic                      err_after_wfi,
    output logic                      wfi_seen
);

    localparam int unsigned FifoWidth = AXI_DATA_WIDTH + 1;
    localparam int unsigned CntW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CntW-1:0] FullCount = CntW'(FIFO_DEPTH);

    logic [FifoWidth-1:0] fifo_rdata;
    logic [CntW-1:0]      fifo_count;
    logic                 fifo_empty;
    logic                 ready_en_q;
    logic                 accept, pop;

    rx_state_e   state_q, state_d;
    logic [31:0] beat_count_q, beat_count_d;
    logic [31:0] packet_count_q, packet_count_d;
    logic [31:0] beat_in_pkt_q, beat_in_pkt_d;
    logic        err_early_q, err_early_d;
    logic        err_missing_q, err_missing_d;
    logic        err_after_q, err_after_d;
    logic        wfi_seen_q, wfi_seen_d;

    logic [31:0] beat_n;
    logic        at_interval, is_wfi;

    // Holds tready low until the first clock edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ready_en_q <= 1'b0;
        else        ready_en_q <= 1'b1;
    end

    assign S_AXIS_tready = ready_en_q & (fifo_count != FullCount);
    assign accept        = S_AXIS_tvalid & S_AXIS_tready;
    assign out_valid     = ~fifo_empty;
    assign pop           = out_valid & out_ready;

    trace_rx_fifo #(
        .Width (FifoWidth),
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (accept),
        .wdata ({S_AXIS_tlast, S_AXIS_tdata}),
        .pop   (pop),
        .rdata (fifo_rdata),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign out_last  = fifo_rdata[AXI_DATA_WIDTH];
    assign out_pc    = fifo_rdata[PC_LSB +: XLEN];
    assign out_instr = fifo_rdata[INSTR_LSB +: INSTR_WIDTH];

    assign beat_n      = beat_in_pkt_q + 32'd1;
    assign at_interval = (tlast_interval != 32'd0) && (beat_n == tlast_interval);
    assign is_wfi      = (S_AXIS_tdata[INSTR_LSB +: INSTR_WIDTH] == WFI_INSTRUCTION);

    always_comb begin
        state_d        = state_q;
        beat_count_d   = beat_count_q;
        packet_count_d = packet_count_q;
        beat_in_pkt_d  = beat_in_pkt_q;
        err_early_d    = err_early_q;
        err_missing_d  = err_missing_q;
        err_after_d    = err_after_q;
        wfi_seen_d     = wfi_seen_q;

        if (ctrl_clear) begin
            state_d        = RX_IDLE;
            beat_count_d   = '0;
            packet_count_d = '0;
            beat_in_pkt_d  = '0;
            err_early_d    = 1'b0;
            err_missing_d  = 1'b0;
            err_after_d    = 1'b0;
            wfi_seen_d     = 1'b0;
        end else if (accept) begin
            beat_count_d  = beat_count_q + 32'd1;
            if (S_AXIS_tlast) packet_count_d = packet_count_q + 32'd1;
            beat_in_pkt_d = (S_AXIS_tlast || at_interval) ? 32'd0 : beat_n;

            if (tlast_interval != 32'd0 && S_AXIS_tlast && !at_interval && !is_wfi)
                err_early_d = 1'b1;
            // WFI must always carry tlast, independent of the interval check.
            if ((!S_AXIS_tlast && at_interval) || (is_wfi && !S_AXIS_tlast))
                err_missing_d = 1'b1;

            unique case (state_q)
                RX_IDLE: if (!S_AXIS_tlast) state_d = RX_BODY;
                RX_BODY: if (S_AXIS_tlast)  state_d = RX_IDLE;
                RX_DONE: err_after_d = 1'b1;
                default: state_d = RX_IDLE;
            endcase

            if (is_wfi && S_AXIS_tlast && state_q != RX_DONE) begin
                wfi_seen_d = 1'b1;
                state_d    = RX_DONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= RX_IDLE;
            beat_count_q   <= '0;
            packet_count_q <= '0;
            beat_in_pkt_q  <= '0;
            err_early_q    <= 1'b0;
            err_missing_q  <= 1'b0;
            err_after_q    <= 1'b0;
            wfi_seen_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            beat_count_q   <= beat_count_d;
            packet_count_q <= packet_count_d;
            beat_in_pkt_q  <= beat_in_pkt_d;
            err_early_q    <= err_early_d;
            err_missing_q  <= err_missing_d;
            err_after_q    <= err_after_d;
            wfi_seen_q     <= wfi_seen_d;
        end
    end

    assign beat_count        = beat_count_q;
    assign packet_count      = packet_count_q;
    assign err_early_tlast   = err_early_q;
    assign err_missing_tlast = err_missing_q;
    assign err_after_wfi     = err_after_q;
    assign wfi_seen          = wfi_seen_q;

endmodule

// File: tb/tb_trace_stream_receiver.sv
// Self-checking bench for trace_stream_receiver: directed scenarios plus
// randomized traffic against a queue-based reference model.
module tb_trace_stream_receiver;

    localparam int unsigned XLEN  = 64;
    localparam int unsigned DW    = XLEN + 32;
    localparam int unsigned DEPTH = 8;

    logic          clk, rst_n;
    logic          tvalid, tready, tlast;
    logic [DW-1:0] tdata;
    logic [31:0]   interval;
    logic          out_valid, out_ready, out_last;
    logic [63:0]   out_pc;
    logic [31:0]   out_instr;
    logic          ctrl_clear;
    logic [31:0]   beat_count, packet_count;
    logic          err_early, err_missing, err_after, wfi_seen;

    trace_stream_receiver #(
        .XLEN           (XLEN),
        .AXI_DATA_WIDTH (DW),
        .FIFO_DEPTH     (DEPTH),
        .WFI_INSTRUCTION(32'h0000_0001)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .S_AXIS_tvalid    (tvalid),
        .S_AXIS_tready    (tready),
        .S_AXIS_tdata     (tdata),
        .S_AXIS_tlast     (tlast),
        .tlast_interval   (interval),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_pc           (out_pc),
        .out_instr        (out_instr),
        .out_last         (out_last),
        .ctrl_clear       (ctrl_clear),
        .beat_count       (beat_count),
        .packet_count     (packet_count),
        .err_early_tlast  (err_early),
        .err_missing_tlast(err_missing),
        .err_after_wfi    (err_after),
        .wfi_seen         (wfi_seen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        last;
    } beat_t;

    beat_t       mq[$];
    bit          m_init, m_early, m_missing, m_after, m_wfi, m_done;
    int unsigned m_beats, m_pkts, m_bip;
    bit          last_acc;
    int          n_checks, n_errors;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_ready();
        return m_init && (mq.size() < DEPTH);
    endfunction

    function automatic void model_zero_status();
        m_beats = 0; m_pkts = 0; m_bip = 0;
        m_early = 0; m_missing = 0; m_after = 0; m_wfi = 0; m_done = 0;
    endfunction

    function automatic void model_beat(beat_t b, logic [31:0] itv);
        int unsigned n   = m_bip + 1;
        bit          hit = (itv != 0) && (n == itv);
        bit          wfi = (b.instr == 32'h1);
        m_beats++;
        if (b.last) m_pkts++;
        if (itv != 0 && b.last && !hit && !wfi) m_early = 1;
        if ((!b.last && hit) || (wfi && !b.last)) m_missing = 1;
        if (m_done) m_after = 1;
        if (wfi && b.last) begin
            m_wfi = 1;
            m_done = 1;
        end
        m_bip = (b.last || hit) ? 0 : n;
    endfunction

    task automatic check_outputs();
        check_eq("tready", tready, model_ready());
        check_eq("out_valid", out_valid, mq.size() > 0);
        if (mq.size() > 0) begin
            check_eq("out_pc", out_pc, mq[0].pc);
            check_eq("out_instr", out_instr, mq[0].instr);
            check_eq("out_last", out_last, mq[0].last);
        end
        check_eq("beat_count", beat_count, m_beats);
        check_eq("packet_count", packet_count, m_pkts);
        check_eq("err_early", err_early, m_early);
        check_eq("err_missing", err_missing, m_missing);
        check_eq("err_after_wfi", err_after, m_after);
        check_eq("wfi_seen", wfi_seen, m_wfi);
    endtask

    // One clock: predict handshake, advance model on the edge, check #1 after.
    task automatic cycle();
        bit          acc, pop, clr;
        beat_t       b;
        logic [31:0] itv;
        acc = tvalid && model_ready();
        pop = (mq.size() != 0) && out_ready;
        clr = ctrl_clear;
        itv = interval;
        b.pc = tdata[DW-1:32];
        b.instr = tdata[31:0];
        b.last = tlast;
        @(posedge clk);
        if (pop) void'(mq.pop_front());
        if (acc) mq.push_back(b);
        if (clr) model_zero_status();
        else if (acc) model_beat(b, itv);
        m_init = 1;
        last_acc = acc;
        #1;
        check_outputs();
    endtask

    task automatic send_beat(input logic [63:0] pc, input logic [31:0] instr, input logic last);
        tvalid = 1'b1;
        tdata = {pc, instr};
        tlast = last;
        for (int i = 0; i < 100; i++) begin
            cycle();
            if (last_acc) break;
        end
        if (!last_acc) check_eq("send_timeout", 64'd0, 64'd1);
        tvalid = 1'b0;
        tlast = 1'b0;
    endtask

    task automatic pulse_clear();
        ctrl_clear = 1'b1;
        cycle();
        ctrl_clear = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 2 * DEPTH; i++) cycle();
    endtask

    initial begin
        int accepted;
        n_checks = 0; n_errors = 0;
        m_init = 0; last_acc = 0;
        model_zero_status();
        rst_n = 1'b0; tvalid = 1'b0; tlast = 1'b0; tdata = '0;
        interval = 32'd0; out_ready = 1'b0; ctrl_clear = 1'b0;
        #1;
        check_outputs();
        #11 rst_n = 1'b1;
        cycle();
        check_eq("tready_after_release", tready, 1'b1);

        // Two 4-beat packets streamed with a consumer that is always ready.
        interval = 32'd4;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send_beat(64'h1000 + 64'(4 * i), 32'h13, (i == 3) || (i == 7));
            check_eq("latency_pc", out_pc, 64'h1000 + 64'(4 * i));
        end
        cycle();
        check_eq("t1_beats", beat_count, 32'd8);
        check_eq("t1_pkts", packet_count, 32'd2);
        check_eq("t1_errs", {err_early, err_missing, err_after}, 3'b000);

        // Backpressure: only DEPTH of ten offered beats fit.
        pulse_clear();
        interval = 32'd0;
        out_ready = 1'b0;
        tvalid = 1'b1;
        tlast = 1'b0;
        accepted = 0;
        for (int i = 0; i < 10; i++) begin
            tdata = {64'h2000 + 64'(accepted), 32'h13};
            cycle();
            if (last_acc) accepted++;
        end
        check_eq("bp_accepted", accepted, DEPTH);
        check_eq("bp_tready_full", tready, 1'b0);
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        tvalid = 1'b0;
        check_eq("bp_tready_back", tready, 1'b1);
        drain();
        check_eq("bp_beats", beat_count, 32'd8);

        // Early tlast on a normal instruction.
        pulse_clear();
        interval = 32'd4;
        send_beat(64'h3000, 32'h13, 1'b0);
        send_beat(64'h3004, 32'h13, 1'b1);
        check_eq("early_err", err_early, 1'b1);

        // Early tlast on WFI is legal and ends the trace.
        pulse_clear();
        send_beat(64'h3100, 32'h13, 1'b0);
        send_beat(64'h3104, 32'h1, 1'b1);
        check_eq("wfi_seen", wfi_seen, 1'b1);
        check_eq("wfi_no_err", {err_early, err_missing, err_after}, 3'b000);
        send_beat(64'h3108, 32'h13, 1'b0);
        check_eq("after_wfi", err_after, 1'b1);
        pulse_clear();
        check_eq("clr_all", {beat_count, packet_count, 28'd0, err_early, err_missing,
                             err_after, wfi_seen}, 64'd0);
        send_beat(64'h3200, 32'h13, 1'b1);
        check_eq("clr_fsm_idle", err_after, 1'b0);

        // Missing tlast at the interval, then the count restarts.
        pulse_clear();
        interval = 32'd3;
        for (int i = 0; i < 3; i++) send_beat(64'h4000 + 64'(4 * i), 32'h13, 1'b0);
        check_eq("missing_err", err_missing, 1'b1);
        send_beat(64'h400c, 32'h13, 1'b0);
        send_beat(64'h4010, 32'h13, 1'b0);
        send_beat(64'h4014, 32'h13, 1'b1);
        check_eq("bip_restart", err_early, 1'b0);

        // WFI without tlast violates the force-tlast rule even with no interval.
        pulse_clear();
        interval = 32'd0;
        send_beat(64'h4100, 32'h1, 1'b0);
        check_eq("wfi_no_tlast", err_missing, 1'b1);
        drain();

        // Asynchronous reset with five beats buffered.
        pulse_clear();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) send_beat(64'h5000 + 64'(4 * i), 32'h13, 1'b0);
        check_eq("rst_pre_beats", beat_count, 32'd5);
        #3 rst_n = 1'b0;
        mq.delete();
        model_zero_status();
        m_init = 0;
        #1;
        check_eq("rst_out_valid", out_valid, 1'b0);
        check_outputs();
        @(posedge clk);
        #2 rst_n = 1'b1;
        cycle();
        check_eq("rst_tready_post", tready, 1'b1);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            if (c % 150 == 0) interval = 32'($urandom_range(0, 5));
            tvalid = ($urandom_range(0, 3) != 0);
            tdata = {$urandom, $urandom, ($urandom_range(0, 7) == 0) ? 32'h1 : $urandom};
            tlast = ($urandom_range(0, 3) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            ctrl_clear = ($urandom_range(0, 59) == 0);
            cycle();
        end
        tvalid = 1'b0;
        ctrl_clear = 1'b0;
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
